// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the mouse-button pulse conditioning path.
package freq_meter_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } deb_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

    // Width that holds 0..cycles inclusive.
    function automatic int deb_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Reusable N-flop synchroniser for a single asynchronous bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_conditioner.sv
// Synchronise, debounce and edge-detect the raw mouse-button pulse; keep a saturating event count.
// Define PULSE_COND_BOTH_EDGES_EN to strobe (and count) on falling transitions as well.
module pulse_conditioner
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             clr_cnt,
    output logic             pulse_out,
    output logic             level_out,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int               DEB_W   = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("pulse_conditioner: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
            $error("pulse_conditioner: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    logic             s;
    deb_state_t       state, state_nxt;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
    logic             level_nxt;
    logic             strobe;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pulse_in),
        .q   (s)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        level_nxt   = level_out;
        unique case (state)
            STABLE: begin
                if (s != level_out) begin
                    state_nxt   = CHECK;
                    deb_cnt_nxt = DEB_ONE;
                end else begin
                    deb_cnt_nxt = '0;
                end
            end
            CHECK: begin
                if (s == level_out) begin
                    state_nxt   = STABLE;
                    deb_cnt_nxt = '0;
                end else if (deb_cnt < DEB_MAX) begin
                    deb_cnt_nxt = deb_cnt + DEB_ONE;
                end else begin
                    level_nxt   = ~level_out;
                    state_nxt   = STABLE;
                    deb_cnt_nxt = '0;
                end
            end
        endcase
    end

    // Strobe is decided from the next level so pulse_out lines up with the level change.
`ifdef PULSE_COND_BOTH_EDGES_EN
    assign strobe = level_nxt ^ level_out;
`else
    assign strobe = level_nxt & ~level_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STABLE;
            deb_cnt   <= '0;
            level_out <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_cnt_nxt;
            level_out <= level_nxt;
            pulse_out <= strobe;
        end
    end

    // A clear coinciding with a strobe keeps that event.
    always_ff @(posedge clk) begin
        if (rst) begin
            event_cnt <= '0;
        end else if (clr_cnt) begin
            event_cnt <= strobe ? CNT_ONE : '0;
        end else if (strobe && (event_cnt != CNT_MAX)) begin
            event_cnt <= event_cnt + CNT_ONE;
        end
    end

endmodule
